pc_redirect: RTL and testbench
==============================

# pc_redirect

Fetch-side program-counter unit. It holds the 9-bit instruction-memory PC and advances it by 4 each cycle. When EX resolves a taken branch, JAL or JALR, it redirects the PC to the target and flushes the wrong-path instruction in IF/ID. It also produces the link address (EX PC + 4) that the writeback mux places in rd.

## Interface
Parameters:
- RESET_PC, 9'h000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; hold PC
- branch_taken  in  1  conditional branch in EX resolved taken
- jal  in  1  EX instruction is JAL
- jalr  in  1  EX instruction is JALR
- pc_ex  in  9  PC of the instruction in EX
- imm  in  32  sign-extended immediate of the EX instruction
- alu_result  in  32  rs1 + imm from ALU (JALR target)
- trap_clear  in  1  acknowledge a misalignment trap (used only with the macro)
- pc  out  9  current fetch PC
- pc_plus4  out  9  pc + 4
- link_addr  out  9  pc_ex + 4, return address for rd
- flush  out  1  kill the IF/ID instruction this cycle
- redirect_valid  out  1  one-cycle pulse: PC was loaded with a target at the last edge
- trap  out  1  misaligned-target trap active (tied 0 without the macro)

## Operation
- FSM states: RUN, BUBBLE, TRAP (TRAP exists only with the macro).
- Target selection uses fixed priority jalr > jal > branch_taken.
  - JALR target: alu_result with bit0 cleared.
  - JAL and branch target: pc_ex + imm.
  - All target arithmetic is done at 32 bits, then truncated to 9 bits.
- RUN:
  - Any redirect input high: pc <= target, next state BUBBLE.
  - Else if stall: pc holds.
  - Else: pc <= pc + 4.
  - Redirect overrides stall, because the EX instruction is older than the stalled one.
- BUBBLE:
  - flush = 1 and redirect_valid = 1.
  - Redirect inputs are ignored, since they belong to the flushed wrong-path instruction.
  - pc <= pc + 4, or pc holds if stall.
  - Next state is RUN.
- Sequential increment wraps modulo 512: 9'h1FC + 4 = 9'h000. pc_plus4 and link_addr wrap the same way.
- link_addr and pc_plus4 are combinational; pc is registered.
- Reset (overrides everything, including mid-BUBBLE and mid-TRAP):
  - pc = RESET_PC, state RUN.
  - flush = 0, redirect_valid = 0, trap = 0.

## Timing
- Redirect sampled at edge t: pc = target at t+1; flush and redirect_valid high for the single cycle t+1 to t+2.
- A redirect asserted in the cycle right after another redirect is ignored, because the state is BUBBLE.
- stall held N cycles in RUN with no redirect: pc is constant for exactly N cycles.
- Latency from redirect input to new PC on the output is 1 cycle. There is no combinational path from the redirect inputs to pc.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A selected target with bit1 = 1 enters TRAP at the next edge instead of redirecting.
  - In TRAP: pc holds the faulting target's predecessor (the value before the edge), trap = 1, flush = 1.
  - All redirect and stall inputs are ignored in TRAP.
  - trap_clear high at an edge: back to RUN, trap = 0 the following cycle, pc resumes at pc + 4.
- MISALIGN_TRAP_EN undefined:
  - Target bits [1:0] are forced to 00 and there is no TRAP state.
  - trap is tied to 0 and trap_clear is ignored.

## Structure
- Shared package pc_pkg holds:
  - PC_W = 9
  - pc_t (logic [PC_W-1:0])
  - the state enum pc_state_t {RUN, BUBBLE, TRAP}
  - the default RESET_PC constant.
- Sub-module pc_target_calc: combinational priority select and target arithmetic (width truncation, bit0 clear, alignment masking or misalign detect). It outputs target and redirect. The FSM and PC register stay in pc_redirect.

## Test plan
- Reset then 4 free-run cycles -> pc = 0x000, 0x004, 0x008, 0x00C, 0x010; flush = 0 throughout.
- pc_ex = 0x020, imm = 0x10, branch_taken = 1 for one cycle -> next pc = 0x030; flush = 1 and redirect_valid = 1 for exactly one cycle; pc = 0x034 after.
- jalr = 1, jal = 1, alu_result = 0x0000_0041, pc_ex = 0x000, imm = 0x80 together -> pc = 0x040 (JALR wins, bit0 cleared); link_addr = 0x004.
- Redirect held for two consecutive cycles (second target 0x100) -> second redirect ignored; pc = target1, then target1 + 4. Separately, stall = 1 with branch_taken = 1 -> redirect taken.
- pc at 0x1FC, no redirect -> pc = 0x000. Separately, jal with pc_ex = 0x1F0, imm = 0x20 -> pc = 0x010 (truncated).
- MISALIGN_TRAP_EN, jal target 0x022 -> trap = 1 and pc held until trap_clear; then RUN resumes. Without the macro, the same stimulus gives pc = 0x020.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC unit.
package pc_pkg;

  localparam int unsigned PC_W = 9;

  typedef logic [PC_W-1:0] pc_t;

  // TRAP is only reachable when MISALIGN_TRAP_EN is defined.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    TRAP   = 2'd2
  } pc_state_t;

  localparam pc_t RESET_PC_DEFAULT = pc_t'(0);
  localparam pc_t PC_STEP          = pc_t'(4);

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target selection: fixed priority jalr > jal > branch_taken.
// Arithmetic is 32 bits wide, then truncated to the PC width.
// MISALIGN_TRAP_EN: report bit1 of the target instead of masking it.
module pc_target_calc
  import pc_pkg::*;
(
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch_taken,
  input  pc_t         pc_ex,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output pc_t         target,
  output logic        redirect,
  output logic        misalign
);

  logic [31:0] rel_sum;
  logic [31:0] abs_sum;
  logic [31:0] sel_sum;

  // Priority select of the full-width target and the redirect request.
  always_comb begin
    rel_sum  = 32'(pc_ex) + imm;
    abs_sum  = alu_result & ~32'h0000_0001;
    sel_sum  = jalr ? abs_sum : rel_sum;
    redirect = jalr | jal | branch_taken;
  end

`ifdef MISALIGN_TRAP_EN
  assign target   = sel_sum[PC_W-1:0];
  assign misalign = redirect & sel_sum[1];

  logic unused_hi;
  assign unused_hi = ^sel_sum[31:PC_W];
`else
  // Without the trap, force word alignment on every target.
  assign target   = {sel_sum[PC_W-1:2], 2'b00};
  assign misalign = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{sel_sum[31:PC_W], sel_sum[1:0]};
`endif

endmodule

// File: rtl/pc_redirect.sv
// Fetch PC register with EX-stage redirect and one-cycle wrong-path flush.
// Optional feature macro: MISALIGN_TRAP_EN (trap on targets with bit1 set).
module pc_redirect
  import pc_pkg::*;
#(
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [8:0]  pc_ex,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        trap_clear,
  output logic [8:0]  pc,
  output logic [8:0]  pc_plus4,
  output logic [8:0]  link_addr,
  output logic        flush,
  output logic        redirect_valid,
  output logic        trap
);

  pc_state_t state, state_nxt;
  pc_t       pc_r, pc_nxt, pc_inc;
  pc_t       target;
  logic      redirect;
  logic      misalign;
  logic      flush_r;
  logic      redirect_valid_r;

  pc_target_calc u_target (
    .jal          (jal),
    .jalr         (jalr),
    .branch_taken (branch_taken),
    .pc_ex        (pc_ex),
    .imm          (imm),
    .alu_result   (alu_result),
    .target       (target),
    .redirect     (redirect),
    .misalign     (misalign)
  );

  assign pc_inc = pc_r + PC_STEP;

  // Next-state and next-PC selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_r;
    case (state)
      RUN: begin
        // Redirect beats stall: the EX instruction is older than the stalled one.
        if (redirect) begin
`ifdef MISALIGN_TRAP_EN
          if (misalign) begin
            state_nxt = TRAP;
          end else begin
            pc_nxt    = target;
            state_nxt = BUBBLE;
          end
`else
          pc_nxt    = target;
          state_nxt = BUBBLE;
`endif
        end else if (!stall) begin
          pc_nxt = pc_inc;
        end
      end
      BUBBLE: begin
        // Redirect inputs here belong to the flushed wrong-path instruction.
        state_nxt = RUN;
        if (!stall) begin
          pc_nxt = pc_inc;
        end
      end
`ifdef MISALIGN_TRAP_EN
      TRAP: begin
        if (trap_clear) begin
          state_nxt = RUN;
          pc_nxt    = pc_inc;
        end
      end
`endif
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State, PC and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      pc_r             <= RESET_PC;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc_r             <= pc_nxt;
      flush_r          <= (state_nxt != RUN);
      redirect_valid_r <= (state_nxt == BUBBLE);
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_r;

  // Trap flag tracks entry into and exit from TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_r <= 1'b0;
    end else begin
      trap_r <= (state_nxt == TRAP);
    end
  end

  assign trap = trap_r;
`else
  assign trap = 1'b0;

  logic unused_trap;
  assign unused_trap = trap_clear ^ misalign;
`endif

  assign pc             = pc_r;
  assign pc_plus4       = pc_inc;
  assign link_addr      = pc_ex + PC_STEP;
  assign flush          = flush_r;
  assign redirect_valid = redirect_valid_r;

endmodule

// File: tb/tb_pc_redirect.sv
// Scoreboard bench for pc_redirect: driver queues expected post-edge state,
// monitor pops and compares one entry per clock edge.
module tb_pc_redirect;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic        jal;
  logic        jalr;
  logic [8:0]  pc_ex;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        trap_clear;
  logic [8:0]  pc;
  logic [8:0]  pc_plus4;
  logic [8:0]  link_addr;
  logic        flush;
  logic        redirect_valid;
  logic        trap;

  typedef struct {
    logic [8:0] pc;
    logic       flush;
    logic       rv;
    logic       trap;
    logic       chk_link;
    logic [8:0] link;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_redirect #(.RESET_PC(9'h000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .jal            (jal),
    .jalr           (jalr),
    .pc_ex          (pc_ex),
    .imm            (imm),
    .alu_result     (alu_result),
    .trap_clear     (trap_clear),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .link_addr      (link_addr),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .trap           (trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: compare DUT state one time unit after each rising edge.
  always begin
    exp_t e;
    logic [8:0] want_p4;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      want_p4 = e.pc + 9'd4;
      chk("pc", 32'(pc), 32'(e.pc));
      chk("pc_plus4", 32'(pc_plus4), 32'(want_p4));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      chk("trap", 32'(trap), 32'(e.trap));
      if (e.chk_link) chk("link_addr", 32'(link_addr), 32'(e.link));
    end
  end

  // Queue the expected state after the next edge, then advance one cycle.
  task automatic cyc(input logic [8:0] p, input logic f, input logic rv,
                     input logic tr, input logic cl = 1'b0, input logic [8:0] lk = 9'h0);
    exp_t e;
    e.pc = p; e.flush = f; e.rv = rv; e.trap = tr; e.chk_link = cl; e.link = lk;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redir_off();
    branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0;
    pc_ex = 9'h0; imm = 32'h0; alu_result = 32'h0; trap_clear = 1'b0;
    @(negedge clk);

    // Reset and free run
    cyc(9'h000, 0, 0, 0);
    reset = 1'b0;
    cyc(9'h004, 0, 0, 0);
    cyc(9'h008, 0, 0, 0);
    cyc(9'h00C, 0, 0, 0);
    cyc(9'h010, 0, 0, 0);

    // Taken branch 0x20 + 0x10
    pc_ex = 9'h020; imm = 32'h10; branch_taken = 1'b1;
    cyc(9'h030, 1, 1, 0, 1, 9'h024);
    redir_off();
    cyc(9'h034, 0, 0, 0);
    cyc(9'h038, 0, 0, 0);

    // JALR wins over JAL, bit0 cleared
    jalr = 1'b1; jal = 1'b1; alu_result = 32'h0000_0041; pc_ex = 9'h000; imm = 32'h80;
    cyc(9'h040, 1, 1, 0, 1, 9'h004);
    redir_off();
    cyc(9'h044, 0, 0, 0);

    // Back-to-back redirect: second is ignored in BUBBLE
    branch_taken = 1'b1; pc_ex = 9'h050; imm = 32'h10;
    cyc(9'h060, 1, 1, 0);
    pc_ex = 9'h0F0; imm = 32'h10;
    cyc(9'h064, 0, 0, 0);
    redir_off();
    cyc(9'h068, 0, 0, 0);

    // Stall holds PC for exactly 3 cycles
    stall = 1'b1;
    cyc(9'h068, 0, 0, 0);
    cyc(9'h068, 0, 0, 0);
    cyc(9'h068, 0, 0, 0);
    stall = 1'b0;
    cyc(9'h06C, 0, 0, 0);

    // Redirect overrides stall; stall then holds in BUBBLE
    stall = 1'b1; branch_taken = 1'b1; pc_ex = 9'h080; imm = 32'h40;
    cyc(9'h0C0, 1, 1, 0);
    redir_off();
    cyc(9'h0C0, 0, 0, 0);
    stall = 1'b0;
    cyc(9'h0C4, 0, 0, 0);

    // Sequential wrap 0x1FC -> 0x000
    jal = 1'b1; pc_ex = 9'h1F0; imm = 32'h8;
    cyc(9'h1F8, 1, 1, 0, 1, 9'h1F4);
    redir_off();
    cyc(9'h1FC, 0, 0, 0);
    cyc(9'h000, 0, 0, 0);

    // JAL target truncated: 0x1F0 + 0x20 = 0x210 -> 0x010
    jal = 1'b1; pc_ex = 9'h1F0; imm = 32'h20;
    cyc(9'h010, 1, 1, 0, 1, 9'h1F4);
    redir_off();
    cyc(9'h014, 0, 0, 0);

    // Negative immediate: 0x100 - 0x10
    branch_taken = 1'b1; pc_ex = 9'h100; imm = 32'hFFFF_FFF0;
    cyc(9'h0F0, 1, 1, 0);
    redir_off();
    cyc(9'h0F4, 0, 0, 0);

    // Misaligned JAL target 0x022
    jal = 1'b1; pc_ex = 9'h020; imm = 32'h2;
`ifdef MISALIGN_TRAP_EN
    cyc(9'h0F4, 1, 0, 1);
    jal = 1'b0; stall = 1'b1; branch_taken = 1'b1; pc_ex = 9'h000; imm = 32'h40;
    cyc(9'h0F4, 1, 0, 1);
    redir_off(); stall = 1'b0; trap_clear = 1'b1;
    cyc(9'h0F8, 0, 0, 0);
    trap_clear = 1'b0;
    cyc(9'h0FC, 0, 0, 0);
`else
    cyc(9'h020, 1, 1, 0);
    redir_off();
    cyc(9'h024, 0, 0, 0);
    trap_clear = 1'b1;
    cyc(9'h028, 0, 0, 0);
    trap_clear = 1'b0;
`endif

    // Reset in the middle of BUBBLE
    branch_taken = 1'b1; pc_ex = 9'h100; imm = 32'h0;
    cyc(9'h100, 1, 1, 0);
    redir_off(); reset = 1'b1;
    cyc(9'h000, 0, 0, 0);
    reset = 1'b0;
    cyc(9'h004, 0, 0, 0);

`ifdef MISALIGN_TRAP_EN
    // Reset in the middle of TRAP
    jal = 1'b1; pc_ex = 9'h020; imm = 32'h2;
    cyc(9'h004, 1, 0, 1);
    redir_off(); reset = 1'b1;
    cyc(9'h000, 0, 0, 0);
    reset = 1'b0;
    cyc(9'h004, 0, 0, 0);
`endif

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
